// File: rtl/alu_instr_sequencer.sv
// Hardwired control sequencer for the single-bus datapath: instruction fetch plus
// execute of register-to-register ALU, MUL/DIV and unary ops, one T-step per cycle.
module alu_instr_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int OPCODE_W = 5,
  parameter int REG_W    = 4,
  parameter int MEM_WAIT = 1
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                start,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic                PCout,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                MDRout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                LOin,
  output logic                HIin,
  output logic                IncPC,
  output logic                Read,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  localparam int OPC_LSB = 32 - OPCODE_W;
  localparam int RA_LSB  = OPC_LSB - REG_W;
  localparam int RB_LSB  = RA_LSB - REG_W;
  localparam int RC_LSB  = RB_LSB - REG_W;

  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ROL = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_MUL = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OP_DIV = OPCODE_W'(16);
  localparam logic [OPCODE_W-1:0] OP_NEG = OPCODE_W'(17);
  localparam logic [OPCODE_W-1:0] OP_NOT = OPCODE_W'(18);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opc_q, opc_d;
  logic [REG_W-1:0]    ra_q, ra_d;
  logic [REG_W-1:0]    rc_q, rc_d;

  logic [OPCODE_W-1:0] opc_ir;
  logic [REG_W-1:0]    ra_ir, rb_ir, rc_ir;

  assign opc_ir = ir[31:OPC_LSB];
  assign ra_ir  = ir[OPC_LSB-1:RA_LSB];
  assign rb_ir  = ir[RA_LSB-1:RB_LSB];
  assign rc_ir  = ir[RB_LSB-1:RC_LSB];

  generate
    if (RC_LSB > 0) begin : g_spare_bits
      logic unused_ir;
      assign unused_ir = ^ir[RC_LSB-1:0];
    end
  endgenerate

  function automatic logic is_muldiv(input logic [OPCODE_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_unary(input logic [OPCODE_W-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return ((op >= OP_ADD) && (op <= OP_ROL)) || is_muldiv(op) || is_unary(op);
  endfunction

  // Indices at or above NUM_REGS decode to no select at all.
  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [REG_W-1:0] idx);
    logic [NUM_REGS-1:0] sel;
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == REG_W'(i)) sel[i] = 1'b1;
    end
    return sel;
  endfunction

  // NOTE: state and latched fields use non-blocking assignments so every flop
  // samples the pre-edge values; the latched fields are reset too so T4..T6
  // decode never sees X after an aborted instruction.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      ra_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      ra_q    <= ra_d;
      rc_q    <= rc_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    ra_d    = ra_q;
    rc_d    = rc_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (!((MEM_WAIT != 0) && !mem_ready)) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (is_legal(opc_ir)) begin
          state_d = S_T4;
          opc_d   = opc_ir;
          ra_d    = ra_ir;
          rc_d    = rc_ir;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = is_muldiv(opc_q) ? S_T6 : S_DONE;
      S_T6:   state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    alu_op   = '0;
    done     = 1'b0;
    illegal  = 1'b0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      // PCin stays high across wait cycles; Z holds PC+1 so reloading is harmless.
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (is_legal(opc_ir)) begin
          Rout = reg_sel(rb_ir);
          Yin  = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        Zin    = 1'b1;
        alu_op = opc_q;
        if (!is_unary(opc_q)) Rout = reg_sel(rc_q);
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (is_muldiv(opc_q)) LOin = 1'b1;
        else                  Rin  = reg_sel(ra_q);
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench: a step-list model of the fetch/execute sequence is compared
// against two sequencer instances (16 regs with memory wait, 8 regs without) every cycle.
module tb_alu_instr_sequencer;

  typedef struct packed {
    logic pcout, zlowout, zhighout, mdrout, marin, zin, pcin, mdrin;
    logic irin, yin, loin, hiin, incpc, read;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu_op;
    logic busy, done, illegal;
  } outs_t;

  localparam logic [4:0] OPC_AND = 5'b00101;
  localparam logic [4:0] OPC_MUL = 5'b01111;
  localparam logic [4:0] OPC_DIV = 5'b10000;

  logic        Clock, Clear, start, mem_ready;
  logic [31:0] ir;

  logic        pcout_a, zlowout_a, zhighout_a, mdrout_a, marin_a, zin_a, pcin_a, mdrin_a;
  logic        irin_a, yin_a, loin_a, hiin_a, incpc_a, read_a, busy_a, done_a, illegal_a;
  logic [15:0] rin_a, rout_a;
  logic [4:0]  alu_op_a;

  logic        pcout_b, zlowout_b, zhighout_b, mdrout_b, marin_b, zin_b, pcin_b, mdrin_b;
  logic        irin_b, yin_b, loin_b, hiin_b, incpc_b, read_b, busy_b, done_b, illegal_b;
  logic [7:0]  rin_b, rout_b;
  logic [4:0]  alu_op_b;

  outs_t got, got_nw;
  outs_t q[$];
  outs_t q_nw[$];
  outs_t trace [64];
  outs_t trace_nw [64];

  int checks = 0;
  int errors = 0;

  alu_instr_sequencer #(.NUM_REGS(16), .OPCODE_W(5), .REG_W(4), .MEM_WAIT(1)) dut (
    .Clock(Clock), .Clear(Clear), .start(start), .ir(ir), .mem_ready(mem_ready),
    .PCout(pcout_a), .Zlowout(zlowout_a), .Zhighout(zhighout_a), .MDRout(mdrout_a),
    .MARin(marin_a), .Zin(zin_a), .PCin(pcin_a), .MDRin(mdrin_a), .IRin(irin_a),
    .Yin(yin_a), .LOin(loin_a), .HIin(hiin_a), .IncPC(incpc_a), .Read(read_a),
    .Rin(rin_a), .Rout(rout_a), .alu_op(alu_op_a), .busy(busy_a), .done(done_a),
    .illegal(illegal_a)
  );

  alu_instr_sequencer #(.NUM_REGS(8), .OPCODE_W(5), .REG_W(4), .MEM_WAIT(0)) dut_nw (
    .Clock(Clock), .Clear(Clear), .start(start), .ir(ir), .mem_ready(mem_ready),
    .PCout(pcout_b), .Zlowout(zlowout_b), .Zhighout(zhighout_b), .MDRout(mdrout_b),
    .MARin(marin_b), .Zin(zin_b), .PCin(pcin_b), .MDRin(mdrin_b), .IRin(irin_b),
    .Yin(yin_b), .LOin(loin_b), .HIin(hiin_b), .IncPC(incpc_b), .Read(read_b),
    .Rin(rin_b), .Rout(rout_b), .alu_op(alu_op_b), .busy(busy_b), .done(done_b),
    .illegal(illegal_b)
  );

  always_comb begin
    got = '{pcout: pcout_a, zlowout: zlowout_a, zhighout: zhighout_a, mdrout: mdrout_a,
            marin: marin_a, zin: zin_a, pcin: pcin_a, mdrin: mdrin_a, irin: irin_a,
            yin: yin_a, loin: loin_a, hiin: hiin_a, incpc: incpc_a, read: read_a,
            rin: rin_a, rout: rout_a, alu_op: alu_op_a, busy: busy_a, done: done_a,
            illegal: illegal_a};
    got_nw = '{pcout: pcout_b, zlowout: zlowout_b, zhighout: zhighout_b, mdrout: mdrout_b,
               marin: marin_b, zin: zin_b, pcin: pcin_b, mdrin: mdrin_b, irin: irin_b,
               yin: yin_b, loin: loin_b, hiin: hiin_b, incpc: incpc_b, read: read_b,
               rin: {8'h00, rin_b}, rout: {8'h00, rout_b}, alu_op: alu_op_b, busy: busy_b,
               done: done_b, illegal: illegal_b};
  end

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [15:0] sel(input int idx, input int nregs);
    return (idx < nregs) ? (16'h0001 << idx) : 16'h0000;
  endfunction

  task automatic add(input outs_t o, input bit to_nw);
    if (to_nw) q_nw.push_back(o);
    else       q.push_back(o);
  endtask

  // Expected outputs cycle by cycle, starting with the IDLE cycle in which start is seen.
  task automatic push_seq(input logic [31:0] irv, input int waits, input bit mw,
                          input int nregs, input bit to_nw);
    logic [4:0] opc;
    int ra, rb, rc;
    bit muldiv, unary, legal;
    outs_t o;
    opc = irv[31:27];
    ra = int'(irv[26:23]);
    rb = int'(irv[22:19]);
    rc = int'(irv[18:15]);
    muldiv = (opc == OPC_MUL) || (opc == OPC_DIV);
    unary  = (opc == 5'b10001) || (opc == 5'b10010);
    legal  = muldiv || unary || (opc >= 5'b00011 && opc <= 5'b01010);
    o = '0; add(o, to_nw);
    o = '0; o.busy = 1; o.pcout = 1; o.marin = 1; o.incpc = 1; o.zin = 1; add(o, to_nw);
    for (int i = 0; i <= (mw ? waits : 0); i++) begin
      o = '0; o.busy = 1; o.zlowout = 1; o.pcin = 1; o.read = 1; o.mdrin = 1; add(o, to_nw);
    end
    o = '0; o.busy = 1; o.mdrout = 1; o.irin = 1; add(o, to_nw);
    if (!legal) begin
      o = '0; o.busy = 1; o.illegal = 1; add(o, to_nw);
      return;
    end
    o = '0; o.busy = 1; o.rout = sel(rb, nregs); o.yin = 1; add(o, to_nw);
    o = '0; o.busy = 1; o.zin = 1; o.alu_op = opc; o.rout = unary ? 16'h0 : sel(rc, nregs);
    add(o, to_nw);
    if (muldiv) begin
      o = '0; o.busy = 1; o.zlowout = 1; o.loin = 1; add(o, to_nw);
      o = '0; o.busy = 1; o.zhighout = 1; o.hiin = 1; add(o, to_nw);
    end else begin
      o = '0; o.busy = 1; o.zlowout = 1; o.rin = sel(ra, nregs); add(o, to_nw);
    end
    o = '0; o.busy = 1; o.done = 1; add(o, to_nw);
  endtask

  // Compare both instances against the model on every falling edge.
  always @(negedge Clock) begin
    outs_t e;
    e = (q.size() != 0) ? q.pop_front() : outs_t'(0);
    check("dut16_wait_outputs", got, e);
    e = (q_nw.size() != 0) ? q_nw.pop_front() : outs_t'(0);
    check("dut8_nowait_outputs", got_nw, e);
  end

  // Issue one instruction (optionally a second back-to-back with start held) and
  // record the cycle, counted from the start edge, at which done is first seen.
  task automatic run_instr(input logic [31:0] irv, input int waits, input bit hold,
                           output int lat, output int lat_nw);
    int hold_len;
    bit drained;
    @(posedge Clock); #2;
    ir = irv;
    start = 1'b1;
    mem_ready = (waits == 0);
    push_seq(irv, waits, 1'b1, 16, 1'b0);
    push_seq(irv, waits, 1'b0, 8, 1'b1);
    hold_len = 0;
    if (hold) begin
      hold_len = q.size();
      push_seq(irv, waits, 1'b1, 16, 1'b0);
      push_seq(irv, waits, 1'b0, 8, 1'b1);
    end
    for (int i = 0; i < 64; i++) begin
      trace[i] = '0;
      trace_nw[i] = '0;
    end
    trace[0] = got;
    trace_nw[0] = got_nw;
    lat = 0;
    lat_nw = 0;
    drained = 1'b0;
    for (int c = 1; c < 64; c++) begin
      @(posedge Clock); #2;
      if (c > hold_len) start = 1'b0;
      mem_ready = (waits == 0) || (c >= waits + 2);
      trace[c] = got;
      trace_nw[c] = got_nw;
      if (got.done && lat == 0) lat = c;
      if (got_nw.done && lat_nw == 0) lat_nw = c;
      if (q.size() == 0 && q_nw.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    check("sequence_timeout", 64'(drained), 64'd1);
    start = 1'b0;
    mem_ready = 1'b1;
  endtask

  initial begin
    int lat, lat_nw;
    logic [4:0] ops [6];
    logic [31:0] irv;

    Clear = 1'b0;
    start = 1'b0;
    ir = '0;
    mem_ready = 1'b1;
    #1 Clear = 1'b1;
    #1;
    check("reset_outputs_zero", got, 64'd0);
    check("reset_outputs_zero_nw", got_nw, 64'd0);
    repeat (2) @(posedge Clock);
    #2 Clear = 1'b0;
    @(posedge Clock); #2;
    check("idle_after_reset", got, 64'd0);

    // AND R1,R2,R3
    run_instr(32'h2891_8000, 0, 1'b0, lat, lat_nw);
    check("and_t0_pcout", trace[1].pcout, 1);
    check("and_t3_rout", trace[4].rout, 16'h0004);
    check("and_t3_yin", trace[4].yin, 1);
    check("and_t4_rout", trace[5].rout, 16'h0008);
    check("and_t4_alu_op", trace[5].alu_op, OPC_AND);
    check("and_t5_rin", trace[6].rin, 16'h0002);
    check("and_t5_zlowout", trace[6].zlowout, 1);
    check("and_done_cycle", lat, 7);
    check("and_done_cycle_nw", lat_nw, 7);

    // MUL: LO then HI writeback, never a GPR load
    run_instr(32'h7918_0000, 0, 1'b0, lat, lat_nw);
    check("mul_t4_alu_op", trace[5].alu_op, OPC_MUL);
    check("mul_t5_lo", {trace[6].zlowout, trace[6].loin, trace[6].rin}, {2'b11, 16'h0000});
    check("mul_t6_hi", {trace[7].zhighout, trace[7].hiin, trace[7].rin}, {2'b11, 16'h0000});
    check("mul_done_cycle", lat, 8);

    // Memory wait: 3 low cycles stretch T1 to 4 cycles on the waiting instance only
    run_instr(32'h2891_8000, 3, 1'b0, lat, lat_nw);
    for (int c = 2; c <= 5; c++) begin
      check("wait_t1_strobes", {trace[c].zlowout, trace[c].pcin, trace[c].read,
                                trace[c].mdrin, trace[c].irin}, 5'b11110);
    end
    check("wait_done_cycle", lat, 10);
    check("nowait_done_cycle", lat_nw, 7);

    // Illegal opcode 11111
    run_instr(32'hF800_0000, 0, 1'b0, lat, lat_nw);
    check("illegal_pulse_t3", trace[4].illegal, 1);
    check("illegal_busy_drops", trace[5].busy, 0);
    check("illegal_no_done", lat, 0);
    check("illegal_no_done_nw", lat_nw, 0);

    // NOT R5,R6 with start held high through DONE
    run_instr(32'h92B0_0000, 0, 1'b1, lat, lat_nw);
    check("not_t4_zin_rout", {trace[5].zin, trace[5].rout}, {1'b1, 16'h0000});
    check("not_t5_rin", trace[6].rin, 16'h0020);
    check("not_done_cycle", lat, 7);
    check("hold_idle_between", trace[8].busy, 0);
    check("hold_second_t0", trace[9].pcout, 1);
    check("hold_second_done", trace[15].done, 1);

    // ADD R9,R10,R12: out of range for the 8-register instance
    run_instr(32'h1CD6_0000, 0, 1'b0, lat, lat_nw);
    check("oor_rout16", trace[4].rout, 16'h0400);
    check("oor_rout8", trace_nw[4].rout, 16'h0000);
    check("oor_rin8", trace_nw[6].rin, 16'h0000);
    check("oor_not_illegal", lat_nw, 7);

    // Remaining opcode classes, model-checked
    ops[0] = 5'b00100; ops[1] = 5'b00110; ops[2] = 5'b00111;
    ops[3] = 5'b01010; ops[4] = OPC_DIV;  ops[5] = 5'b10001;
    for (int k = 0; k < 6; k++) begin
      irv = {ops[k], 4'(k + 1), 4'(k + 2), 4'(k + 9), 15'd0};
      run_instr(irv, 0, 1'b0, lat, lat_nw);
      check("op_done_cycle", lat, (ops[k] == OPC_DIV) ? 8 : 7);
    end

    // Clear in the middle of T4 aborts without done
    @(posedge Clock); #2;
    ir = 32'h2891_8000;
    start = 1'b1;
    push_seq(ir, 0, 1'b1, 16, 1'b0);
    push_seq(ir, 0, 1'b0, 8, 1'b1);
    repeat (5) begin
      @(posedge Clock); #2;
      start = 1'b0;
    end
    check("pre_clear_t4_alu_op", got.alu_op, OPC_AND);
    Clear = 1'b1;
    q.delete();
    q_nw.delete();
    #1;
    check("clear_async_outputs", got, 64'd0);
    check("clear_async_outputs_nw", got_nw, 64'd0);
    @(posedge Clock); #2;
    check("clear_no_done", got.done, 0);
    Clear = 1'b0;
    repeat (2) @(posedge Clock);
    run_instr(32'h2891_8000, 0, 1'b0, lat, lat_nw);
    check("after_clear_fresh_t0", trace[1].pcout, 1);
    check("after_clear_done_cycle", lat, 7);

    repeat (2) @(posedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
